button_event: RTL
=================

# button_event

Converts the four debounced button levels from the debouncer stage into single-cycle events for the control logic: a press pulse, a release pulse, and an auto-repeating event pulse while a button stays held. It sits directly downstream of the debouncer and upstream of the programmer's command and menu FSM. That FSM consumes only pulses and never polls the levels.

## Interface
Parameters:
- PRESC_BITS, 16: width of the free-running tick prescaler; one tick every 2^PRESC_BITS clocks.
- HOLD_TICKS, 24: ticks from press to the first repeat event; legal range 1..255.
- REPEAT_TICKS, 6: ticks between subsequent repeat events; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- button_in  in  4  debounced levels, already synchronous to clk; 1 = pressed.
- press  out  4  one-cycle pulse per bit on a 0→1 transition.
- release  out  4  one-cycle pulse per bit on a 1→0 transition.
- event  out  4  one-cycle pulse on press and on each auto-repeat.
- held  out  4  registered level; 1 while a bit is in the DELAY or REPEAT state.

## Operation
- Reset clears all of the following to 0: prescaler, btn_q, per-bit state (IDLE), per-bit counters, press, release, event, held.
- The prescaler counts up by 1 every clock and wraps naturally. tick = &prescaler, which is high exactly one cycle in 2^PRESC_BITS. A single prescaler is shared by all four channels.
- btn_q is a registered copy of button_in. rise = button_in & ~btn_q; fall = ~button_in & btn_q.
- Each bit has its own FSM with states IDLE, DELAY and REPEAT, and an 8-bit counter cnt.
  - IDLE, rise: press=1, event=1, cnt←0, go to DELAY.
  - DELAY, fall: release=1, cnt←0, go to IDLE.
  - DELAY, tick with cnt==HOLD_TICKS-1: event=1, cnt←0, go to REPEAT.
  - DELAY, any other tick: cnt←cnt+1.
  - REPEAT, fall: release=1, cnt←0, go to IDLE.
  - REPEAT, tick with cnt==REPEAT_TICKS-1: event=1, cnt←0.
  - REPEAT, any other tick: cnt←cnt+1.
- A fall takes priority over a tick in the same cycle: no event is emitted and the counter does not advance.
- The per-bit pulse outputs default to 0 on every cycle in which the rules above do not assert them.
- The channels are fully independent, so simultaneous transitions on different bits each produce their own pulses in the same cycle.
- A rise seen while the FSM is not in IDLE is impossible by construction. No handling is required beyond remaining in the current state.
- Reset mid-operation aborts all channels with no release pulse. If a button is still high when rst deasserts, btn_q=0 makes it appear as a fresh press: press and event are emitted one cycle after the first clock edge that samples it.

## Timing
- Press latency: button_in is sampled high at edge k with btn_q low. press and event are then high in the cycle after edge k, for exactly one cycle.
- Release latency follows the same rule: release is high in the cycle after the edge that samples the falling level.
- The first repeat fires on the HOLD_TICKS-th tick after entering DELAY. Because ticks are not aligned to presses, the delay is (HOLD_TICKS-1)·2^PRESC_BITS+1 to HOLD_TICKS·2^PRESC_BITS clocks.
- Each following repeat fires exactly REPEAT_TICKS·2^PRESC_BITS clocks after the previous one.
- held rises and falls in the same cycle as press and release respectively.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package button_event_pkg holds:
  - the state encoding as localparams: ST_IDLE=2'd0, ST_DELAY=2'd1, ST_REPEAT=2'd2;
  - NUM_BUTTONS=4;
  - the counter width, 8.
- One sub-module, button_event_channel, implements the per-bit FSM and counter. It takes clk, rst, tick, rise, fall and drives press, release, event and held.
- The top level holds the prescaler and btn_q, and instantiates four channels with a generate loop.

## Test plan
All scenarios use PRESC_BITS=2 (tick every 4 clocks), HOLD_TICKS=3 and REPEAT_TICKS=2.
- Reset, then button_in held at 4'h0 for 100 cycles → every output stays 0.
- Set button_in[0]=1 for 5 cycles, then 0 → one press[0] pulse and one event[0] pulse, held[0] high during the hold, one release[0] pulse; no repeat event.
- Hold button_in[1]=1 for 60 cycles → event[1] pulses at press, again 9–12 clocks later, then every 8 clocks. release[1] pulses once at the end.
- Drop button_in[2] in the same cycle a terminal-count tick arrives → release[2]=1, event[2]=0, FSM returns to IDLE.
- Press buttons 0 and 3 in the same cycle → press[0] and press[3] pulse in the same cycle, and the two channels repeat in lockstep.
- Assert rst while button_in[1] is held in REPEAT → outputs clear immediately with no release pulse. After rst deasserts with the button still high, a new press[1] pulse follows one cycle later.

Source files
------------

// File: rtl/button_event_pkg.sv
// Shared types and constants for the button event block.
// Per-channel state encoding and counter sizing.
package button_event_pkg;

  localparam int NUM_BUTTONS = 4;
  localparam int CNT_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_DELAY  = ST_DELAY,
    S_REPEAT = ST_REPEAT
  } state_e;

endpackage

// File: rtl/button_event_channel.sv
// One button channel: press/release pulses and hold auto-repeat.
// All outputs are registered from the next-state logic.
module button_event_channel
  import button_event_pkg::*;
#(
  parameter int HOLD_TICKS   = 24,
  parameter int REPEAT_TICKS = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic rise,
  input  logic fall,
  output logic press,
  output logic release_pulse,
  output logic event_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST =
    CNT_W'(REPEAT_TICKS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_d, rel_d, evt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      event_pulse   <= 1'b0;
      held          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      press         <= press_d;
      release_pulse <= rel_d;
      event_pulse   <= evt_d;
      held          <= (state_d != S_IDLE);
    end
  end

  // A fall wins over a tick in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    evt_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          evt_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        if (fall) begin
          rel_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (tick) begin
          if (cnt_q == HOLD_LAST) begin
            evt_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_REPEAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_REPEAT: begin
        if (fall) begin
          rel_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (tick) begin
          if (cnt_q == REP_LAST) begin
            evt_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_event.sv
// Debounced button levels to press/release/repeat event pulses.
// Shared tick prescaler, one FSM channel per button.
module button_event
  import button_event_pkg::*;
#(
  parameter int PRESC_BITS   = 16,
  parameter int HOLD_TICKS   = 24,
  parameter int REPEAT_TICKS = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] button_in,
  output logic [NUM_BUTTONS-1:0] press,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_BUTTONS-1:0] event_pulse,
  output logic [NUM_BUTTONS-1:0] held
);

  logic [PRESC_BITS-1:0]  prescaler;
  logic [NUM_BUTTONS-1:0] btn_q;
  logic [NUM_BUTTONS-1:0] rise, fall;
  logic                   tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      btn_q     <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
      btn_q     <= button_in;
    end
  end

  assign tick = &prescaler;
  assign rise = button_in & ~btn_q;
  assign fall = ~button_in & btn_q;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    button_event_channel #(
      .HOLD_TICKS   (HOLD_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .tick          (tick),
      .rise          (rise[i]),
      .fall          (fall[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .event_pulse   (event_pulse[i]),
      .held          (held[i])
    );
  end

endmodule
